pipe_mem_arbiter: RTL and testbench

//  Shares one single-port variable-latency memory between IF (instruction fetch) and MEM (data access driven by
//  the EX/MEM MemRead/MemWrite controls). Sequences each access with a req/ready handshake.

---
 rtl/pipe_mem_pkg.sv | 17 +
 rtl/pipe_mem_arbiter_if.sv | 26 ++
 rtl/mem_watchdog.sv | 40 ++++
 rtl/pipe_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_mem_pkg.sv
// Shared types and width defaults for the pipeline memory arbiter.
package pipe_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Arbiter states
  //   ARB_IDLE      | no access on the RAM port; grant decision happens here
  //   ARB_SERVE_MEM | data access (load/store) in flight
  //   ARB_SERVE_IF  | instruction fetch in flight
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_SERVE_MEM = 2'd1,
    ARB_SERVE_IF  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// RAM-side request/ready bus. master = arbiter, slave = memory.
interface pipe_mem_arbiter_if
  import pipe_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_rdata, ram_ready
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_rdata, ram_ready
  );

endinterface

// File: rtl/mem_watchdog.sv
// Serve-state watchdog for the memory arbiter. Only present when
// MEM_TIMEOUT_EN is defined; the default build contains no counter.
// Down-counter reloaded while cleared; expired_o flags the LIMIT-th
// enabled cycle.
`ifdef MEM_TIMEOUT_EN
module mem_watchdog #(
  parameter int LIMIT = 255
)(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] RELOAD = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: reload on clear, count down while enabled, park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = RELOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = en_i & (cnt_q == '0);

endmodule
`endif

// File: rtl/pipe_mem_arbiter.sv
// Shares one single-port variable-latency RAM between instruction fetch
// and the MEM stage. MEM wins when both pend (it is the older instruction).
// stall freezes the whole pipeline until every access wanted this cycle is
// done. Optional serve watchdog: define MEM_TIMEOUT_EN.
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              timeout_err,
  pipe_mem_arbiter_if.master ram
);

  arb_state_t        state_q, state_d;
  logic              mem_served_q, mem_served_d;
  logic              if_served_q, if_served_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic mem_op, mem_pend, if_pend, serving, wd_fire;

  assign mem_op   = mem_read | mem_write;
  assign mem_pend = mem_op & ~mem_served_q;
  assign if_pend  = if_req & ~if_served_q;
  assign stall    = mem_pend | if_pend;
  assign serving  = (state_q != ARB_IDLE);

`ifdef MEM_TIMEOUT_EN
  logic wd_expired;
  logic timeout_err_q, timeout_err_d;

  mem_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (~serving),
    .en_i      (serving),
    .expired_o (wd_expired)
  );

  // A ready arriving on the expiry cycle still counts as a normal completion
  assign wd_fire       = wd_expired & ~ram.ram_ready;
  assign timeout_err_d = timeout_err_q | wd_fire;

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_err_q <= 1'b0;
    else     timeout_err_q <= timeout_err_d;
  end

  assign timeout_err = timeout_err_q;
`else
  localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Grant, completion and served-bit bookkeeping
  always_comb begin
    state_d      = state_q;
    mem_served_d = mem_served_q;
    if_served_d  = if_served_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (mem_pend) begin
          state_d = ARB_SERVE_MEM;
          we_d    = mem_write;        // read+write together is a write
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
        end else if (if_pend) begin
          state_d = ARB_SERVE_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
        end
      end
      ARB_SERVE_MEM: begin
        if (ram.ram_ready) begin
          state_d      = ARB_IDLE;
          mem_served_d = 1'b1;
          if (!we_q) mem_rdata_d = ram.ram_rdata;
        end else if (wd_fire) begin
          state_d      = ARB_IDLE;
          mem_served_d = 1'b1;
          mem_rdata_d  = '0;
        end
      end
      ARB_SERVE_IF: begin
        if (ram.ram_ready) begin
          state_d     = ARB_IDLE;
          if_served_d = 1'b1;
          if_rdata_d  = ram.ram_rdata;
        end else if (wd_fire) begin
          state_d     = ARB_IDLE;
          if_served_d = 1'b1;
          if_rdata_d  = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Pipeline advances on this edge: the next instruction starts fresh
    if (!stall) begin
      mem_served_d = 1'b0;
      if_served_d  = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      mem_served_q <= 1'b0;
      if_served_q  <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_served_q <= mem_served_d;
      if_served_q  <= if_served_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign ram.ram_req   = serving;
  assign ram.ram_we    = we_q;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;
  assign if_rdata      = if_rdata_q;
  assign mem_rdata     = mem_rdata_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Testbench for pipe_mem_arbiter: directed corner cases plus randomized
// pipeline steps checked against a transaction-level reference model.
module tb_pipe_mem_arbiter;
  import pipe_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_read, mem_write;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata, if_rdata, mem_rdata;
  logic          stall, timeout_err;

  pipe_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ram_bus ();

  pipe_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .timeout_err (timeout_err),
    .ram         (ram_bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] env_mem [256];  // memory the DUT talks to
  logic [31:0] ref_mem [256];  // reference model's view of memory
  logic [31:0] exp_mrd, exp_ird;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One pipeline step: predict the RAM transactions and stall length,
  // then play the memory with the chosen latencies and compare.
  task automatic run_step(input bit rd, input bit wr, input bit ifr,
                          input logic [31:0] ma, input logic [31:0] wd,
                          input logic [31:0] ia, input int lat_m, input int lat_i);
    txn_t exp_q[$];
    txn_t obs_q[$];
    txn_t t;
    int   exp_stall = 0;
    int   n_stall   = 0;
    int   req_cyc   = 0;
    int   idx, lat;

    if (rd | wr) begin
      t.we = wr; t.addr = ma; t.wdata = wd; t.lat = lat_m;
      exp_q.push_back(t);
      if (wr) ref_mem[ma[9:2]] = wd;
      else    exp_mrd = ref_mem[ma[9:2]];
    end
    if (ifr) begin
      t.we = 1'b0; t.addr = ia; t.wdata = '0; t.lat = lat_i;
      exp_q.push_back(t);
      exp_ird = ref_mem[ia[9:2]];
    end
    foreach (exp_q[i]) exp_stall += 2 + exp_q[i].lat;

    mem_read = rd; mem_write = wr; mem_addr = ma; mem_wdata = wd;
    if_req = ifr; if_addr = ia;
    #1;
    while (stall && n_stall < 60) begin
      n_stall++;
      ram_bus.ram_ready = 1'b0;
      ram_bus.ram_rdata = $urandom;
      if (ram_bus.ram_req) begin
        if (req_cyc == 0) begin
          t.we = ram_bus.ram_we; t.addr = ram_bus.ram_addr;
          t.wdata = ram_bus.ram_wdata; t.lat = 0;
          obs_q.push_back(t);
        end
        idx = obs_q.size() - 1;
        lat = (idx < exp_q.size()) ? exp_q[idx].lat : 0;
        if (req_cyc >= lat) begin
          ram_bus.ram_ready = 1'b1;
          if (ram_bus.ram_we) env_mem[ram_bus.ram_addr[9:2]] = ram_bus.ram_wdata;
          else                ram_bus.ram_rdata = env_mem[ram_bus.ram_addr[9:2]];
          req_cyc = 0;
        end else begin
          req_cyc++;
        end
      end
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    ram_bus.ram_ready = 1'b0;

    chk("stall_cycles", n_stall, exp_stall);
    chk("txn_count", obs_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        chk("txn_we", obs_q[i].we, exp_q[i].we);
        chk("txn_addr", obs_q[i].addr, exp_q[i].addr);
        if (exp_q[i].we) chk("txn_wdata", obs_q[i].wdata, exp_q[i].wdata);
      end
    end
    chk("mem_rdata", mem_rdata, exp_mrd);
    chk("if_rdata", if_rdata, exp_ird);
    chk("ram_req_free", ram_bus.ram_req, 1'b0);
    chk("timeout_err", timeout_err, 1'b0);
    // advance edge
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n, r;
    logic [31:0] v;
    rst = 1'b1;
    if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    ram_bus.ram_ready = 1'b0; ram_bus.ram_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    exp_mrd = '0;
    exp_ird = '0;

    #12;
    chk("rst_ram_req", ram_bus.ram_req, 1'b0);
    chk("rst_ram_we", ram_bus.ram_we, 1'b0);
    chk("rst_ram_addr", ram_bus.ram_addr, 32'h0);
    chk("rst_ram_wdata", ram_bus.ram_wdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // load + fetch together, 3-cycle memory: MEM first, then IF
    run_step(1, 0, 1, 32'h40, 32'h0, 32'h0, 3, 3);
    chk("deadbeef", mem_rdata, 32'hDEADBEEF);
    // load with same-cycle ready: two stall cycles
    run_step(1, 0, 0, 32'h44, 32'h0, 32'h0, 0, 0);
    // store
    run_step(0, 1, 0, 32'h100, 32'h1234, 32'h0, 1, 0);
    // read+write together behaves as a write
    run_step(1, 1, 0, 32'h104, 32'hCAFE, 32'h0, 0, 0);
    // no request at all
    run_step(0, 0, 0, 32'h8, 32'h0, 32'h0, 0, 0);

    // reset in the middle of a MEM access
    mem_read = 1'b1; mem_write = 1'b0; mem_addr = 32'h48; if_req = 1'b0;
    ram_bus.ram_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("req_before_rst", ram_bus.ram_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", ram_bus.ram_req, 1'b0);
    chk("rst_mid_we", ram_bus.ram_we, 1'b0);
    chk("rst_mid_mem_rdata", mem_rdata, 32'h0);
    chk("rst_mid_stall", stall, 1'b1);
    exp_mrd = '0;
    exp_ird = '0;
    @(negedge clk);
    rst = 1'b0;
    run_step(1, 0, 0, 32'h48, 32'h0, 32'h0, 2, 0);

    // randomized pipeline steps
    for (int s = 0; s < 60; s++) begin
      run_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 63)) << 2, $urandom, 32'($urandom_range(0, 63)) << 2,
               $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // memory never answers
    mem_read = 1'b1; mem_write = 1'b0; mem_addr = 32'h8; if_req = 1'b0;
    ram_bus.ram_ready = 1'b0;
    #1;
    n = 0;
    r = 0;
    while (stall && n < 40) begin
      n++;
      if (ram_bus.ram_req) r++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
`ifdef MEM_TIMEOUT_EN
    chk("to_stall_cycles", n, 5);
    chk("to_req_cycles", r, TO);
    chk("to_err", timeout_err, 1'b1);
    chk("to_mem_rdata", mem_rdata, 32'h0);
    chk("to_req_dropped", ram_bus.ram_req, 1'b0);
`else
    chk("stuck_stall", stall, 1'b1);
    chk("stuck_req_cycles", r, 39);
    chk("stuck_err", timeout_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
